// File: rtl/seg7_pkg.sv
// Shared types, constants and helpers for the 7-segment scan controller.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Segment bundle, bit 0 = a ... bit 6 = g, 1 = segment lit.
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg7_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Nibble is a legal BCD digit.
  function automatic logic bcd_ok(input logic [3:0] nibble);
    return (nibble <= 4'd9);
  endfunction

endpackage

// File: rtl/BCDto7_struct.sv
// BCD to 7-segment decoder (combinational), 1 = segment lit.
// Ports: bcd  - BCD digit in
//        seg  - segment bundle out; all dark for nibbles above 9
module BCDto7_struct
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output seg7_t      seg
);

  always_comb begin
    seg = seg7_t'(SEG_BLANK);
    case (bcd)
      4'd0: seg = seg7_t'(7'h3F);
      4'd1: seg = seg7_t'(7'h06);
      4'd2: seg = seg7_t'(7'h5B);
      4'd3: seg = seg7_t'(7'h4F);
      4'd4: seg = seg7_t'(7'h66);
      4'd5: seg = seg7_t'(7'h6D);
      4'd6: seg = seg7_t'(7'h7D);
      4'd7: seg = seg7_t'(7'h07);
      4'd8: seg = seg7_t'(7'h7F);
      4'd9: seg = seg7_t'(7'h6F);
      default: seg = seg7_t'(SEG_BLANK);
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode display.
// Ports: clk, reset      - clock, async active-high reset
//        in_valid/ready  - producer handshake, in_data packed BCD (digit k at [4k+3:4k])
//        lzb             - leading-zero blanking enable
//        seg, an         - segment pattern (1 = lit), active-low one-hot digit enables
//        frame_done      - pulse in the last cycle of each scan frame
//        err_bcd         - displayed word holds a nibble above 9
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [4*NUM_DIGITS-1:0] in_data,
  output logic                    in_ready,
  input  logic                    lzb,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    err_bcd
);

  localparam int unsigned DW       = 4 * NUM_DIGITS;
  localparam int unsigned CNT_MAX  = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int unsigned DIV_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned DIG_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SHOW_END = CLK_DIV - 1;
  localparam int unsigned GAP_END  = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam int unsigned DIG_END  = NUM_DIGITS - 1;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SHOW = SHOW;
  localparam logic [1:0] ST_GAP  = GAP;

  logic [1:0]            state, state_nx;
  logic [DIV_W-1:0]      div, div_nx;
  logic [DIG_W-1:0]      digit, digit_nx;
  logic [DW-1:0]         disp, disp_nx;
  logic [DW-1:0]         pend, pend_nx;
  logic                  pend_full, pend_full_nx;
  logic                  lzb_q, lzb_nx;
  logic [6:0]            seg_nx;
  logic [NUM_DIGITS-1:0] an_nx;
  logic                  frame_done_nx;
  logic                  err_nx;
  logic                  in_ready_nx;

  logic                  accept;
  logic                  advance;
  logic                  frame_end;
  logic                  load;
  logic                  all_ok;
  logic                  blank;
  logic [DIG_W-1:0]      hi_digit;
  logic [3:0]            nibble;
  seg7_t                 dec_seg;

  // Shared decoder fed by the digit mux.
  BCDto7_struct u_dec (
    .bcd (nibble),
    .seg (dec_seg)
  );

  // Next-state: scan sequencing, pending/display transfer, handshake.
  always_comb begin
    state_nx     = state;
    div_nx       = div;
    digit_nx     = digit;
    disp_nx      = disp;
    pend_nx      = pend;
    pend_full_nx = pend_full;
    advance      = 1'b0;
    frame_end    = 1'b0;
    load         = 1'b0;
    accept       = in_valid && in_ready;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          disp_nx  = in_data;
          load     = 1'b1;
          state_nx = ST_SHOW;
          div_nx   = '0;
          digit_nx = '0;
        end
      end
      ST_SHOW: begin
        if (div == DIV_W'(SHOW_END)) begin
          div_nx = '0;
          if (BLANK_CYCLES > 0) state_nx = ST_GAP;
          else                  advance  = 1'b1;
        end else begin
          div_nx = div + DIV_W'(1);
        end
      end
      ST_GAP: begin
        if (div == DIV_W'(GAP_END)) begin
          div_nx  = '0;
          advance = 1'b1;
        end else begin
          div_nx = div + DIV_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    if (advance) begin
      state_nx = ST_SHOW;
      if (digit < DIG_W'(DIG_END)) begin
        digit_nx = digit + DIG_W'(1);
      end else begin
        digit_nx  = '0;
        frame_end = 1'b1;
      end
    end

    // Pending only moves at a frame boundary; a same-cycle accept lands in pending.
    if (frame_end && pend_full) begin
      disp_nx      = pend;
      pend_full_nx = 1'b0;
      load         = 1'b1;
    end
    if (accept && state != ST_IDLE) begin
      pend_nx      = in_data;
      pend_full_nx = 1'b1;
    end
  end

  // Output computation from next-state values so pins track the state they describe.
  always_comb begin
    lzb_nx   = lzb_q;
    nibble   = '0;
    hi_digit = '0;
    all_ok   = 1'b1;

    if (state_nx == ST_SHOW && div_nx == '0) lzb_nx = lzb;

    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (DIG_W'(k) == digit_nx) nibble = disp_nx[4*k +: 4];
      if (disp_nx[4*k +: 4] != 4'd0) hi_digit = DIG_W'(k);
      if (!bcd_ok(disp_nx[4*k +: 4])) all_ok = 1'b0;
    end

    // Digit 0 never blanks because hi_digit is never below 0.
    blank = lzb_nx && (digit_nx > hi_digit);

    if (state_nx == ST_SHOW) begin
      an_nx  = ~(NUM_DIGITS'(1) << digit_nx);
      seg_nx = (bcd_ok(nibble) && !blank) ? 7'(dec_seg) : SEG_BLANK;
    end else begin
      an_nx  = '1;
      seg_nx = SEG_BLANK;
    end

    if (BLANK_CYCLES > 0)
      frame_done_nx = (state_nx == ST_GAP) && (div_nx == DIV_W'(GAP_END)) &&
                      (digit_nx == DIG_W'(DIG_END));
    else
      frame_done_nx = (state_nx == ST_SHOW) && (div_nx == DIV_W'(SHOW_END)) &&
                      (digit_nx == DIG_W'(DIG_END));

    err_nx      = load ? !all_ok : err_bcd;
    in_ready_nx = !pend_full_nx;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      div        <= '0;
      digit      <= '0;
      disp       <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      lzb_q      <= 1'b0;
      seg        <= SEG_BLANK;
      an         <= '1;
      frame_done <= 1'b0;
      err_bcd    <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state      <= state_nx;
      div        <= div_nx;
      digit      <= digit_nx;
      disp       <= disp_nx;
      pend       <= pend_nx;
      pend_full  <= pend_full_nx;
      lzb_q      <= lzb_nx;
      seg        <= seg_nx;
      an         <= an_nx;
      frame_done <= frame_done_nx;
      err_bcd    <= err_nx;
      in_ready   <= in_ready_nx;
    end
  end

endmodule
